mp_addsub_chunked: RTL
======================

Name: mp_addsub_chunked

Overview:
- Parametrised multi-precision adder/subtractor with an optional 1-bit right shift for the Montgomery datapath.
- Processes operands CHUNK bits per cycle, least-significant chunk first, with the carry held in a register between chunks.
- Uses valid/ready handshakes on both input and output, so it can sit between the Montgomery controller and the operand registers without the caller counting cycles.
- Width and chunk size are parameters; the RSA configuration uses WIDTH=514 and CHUNK=128.

Parameters:
- WIDTH, 514: operand width in bits. The result is WIDTH+1 bits.
- CHUNK, 128: bits added per cycle.
- NCHUNK (localparam, derived): ceil((WIDTH+1)/CHUNK), the number of add cycles. For the defaults, NCHUNK=5.

Ports:
- clk  in  1  clock
- resetn  in  1  reset, synchronous, active-low
- in_valid  in  1  operation request
- in_ready  out  1  high only in IDLE
- in_a  in  WIDTH  operand A, unsigned
- in_b  in  WIDTH  operand B, unsigned
- subtract  in  1  0: A+B, 1: A-B; sampled at accept
- shift  in  1  1: logical right shift of the result by one bit; sampled at accept
- out_valid  out  1  result available
- out_ready  in  1  consumer accepts the result
- out_result  out  WIDTH+1  result
- out_carry  out  1  add: carry out (equal to the unshifted bit WIDTH); subtract: 1 iff A>=B

Behaviour:
- Accept:
  - A transfer occurs on a rising edge with in_valid && in_ready.
  - On accept, the block registers A, B, subtract and shift.
  - A and B are zero-extended to NCHUNK*CHUNK bits. If subtract=1, the extended B is inverted.
  - The carry register is set to subtract. The chunk counter is set to 0.
  - in_a and in_b need not be held after accept.
- States:
  - IDLE: in_ready=1. Accept moves to CALC.
  - CALC: each cycle adds chunk k of A, chunk k of B and the carry, then:
    - stores the chunk sum into the result shift register (shifting in from the MSB side);
    - updates the carry;
    - increments k.
    - After chunk NCHUNK-1, moves to HOLD.
  - HOLD: out_valid=1. On out_valid && out_ready, moves to IDLE.
- Latency:
  - For accept at edge t, out_valid rises after edge t+NCHUNK.
  - With NCHUNK=1, out_valid rises after edge t+1.
  - A new accept is possible at the first edge after the output transfer; there is no overlap.
- Arithmetic:
  - Unshifted R = (A ± B) mod 2^(WIDTH+1).
  - For subtract, R is two's complement and R[WIDTH]=1 iff A<B.
  - out_result = R when shift=0; {1'b0, R[WIDTH:1]} when shift=1.
  - out_carry = R[WIDTH] for add; ~R[WIDTH] for subtract. The shift does not affect out_carry.
- Output stability:
  - While out_valid=1 and out_ready=0, out_result and out_carry are held constant.
  - in_valid is ignored outside IDLE.
- Output values outside HOLD:
  - out_result and out_carry are held at their last value (0 after reset).
  - out_valid=0.
- Reset:
  - Applied when resetn=0 at a rising edge, in any state, including mid-CALC.
  - Next state is IDLE; the operation is discarded and no out_valid is produced.
  - Reset values: in_ready=1, out_valid=0, out_result=0, out_carry=0, carry=0, counter=0.
- Boundary values:
  - A=B=0 gives out_result=0; out_carry is 0 for add and 1 for subtract.
  - A=B=2^WIDTH-1 with add gives R=2^(WIDTH+1)-2.
  - Unused high extension bits beyond WIDTH+1 are discarded.

Optional Feature:
- Macro: MP_ADDSUB_COND_SUB_EN.
- When defined:
  - Adds input port cond_sub (1 bit), sampled at accept.
  - If subtract=1, cond_sub=1 and A<B, out_result equals A (zero-extended, then shifted if shift=1) instead of the difference.
  - out_carry still reports A>=B. Latency is unchanged.
  - This is the Montgomery final conditional reduction.
- When undefined: the port is absent and the block behaves as if cond_sub=0.

Test Plan:
- WIDTH=514, CHUNK=128, add, A=2^514-1, B=1 -> out_result=2^514, out_carry=1, out_valid exactly 5 cycles after accept.
- subtract, A=5, B=7 -> out_result=2^515-2, out_carry=0; subtract, A=7, B=5, shift=1 -> out_result=1, out_carry=1.
- out_ready held low 10 cycles in HOLD, with in_valid=1 and new operands -> out_result stable, in_ready=0, second request not accepted; raise out_ready -> IDLE next cycle, second request accepted and correct.
- resetn=0 during the 3rd CALC cycle -> next cycle in_ready=1, out_valid=0, out_result=0; the following add A=3, B=4 -> 7.
- WIDTH=16, CHUNK=5 (NCHUNK=4): 1000 random add/sub/shift operations with random out_ready -> all results match the golden model, latency 4.
- With MP_ADDSUB_COND_SUB_EN: subtract, cond_sub=1, A=5, B=7 -> out_result=5, out_carry=0; A=9, B=7 -> out_result=2, out_carry=1.

Source files
------------

// File: rtl/mp_addsub_chunked.sv
// mp_addsub_chunked: multi-precision adder/subtractor with an optional
// one-bit logical right shift of the result, used by the Montgomery datapath.
// Operands are processed CHUNK bits per cycle, least-significant chunk first,
// with the inter-chunk carry held in a register. Valid/ready on both sides.
// Optional feature macro: MP_ADDSUB_COND_SUB_EN adds the cond_sub input
// (conditional subtraction: keep A when A<B). Default build omits it.
module mp_addsub_chunked #(
  parameter int WIDTH = 514,
  parameter int CHUNK = 128
) (
  input  logic             clk,
  input  logic             resetn,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_a,
  input  logic [WIDTH-1:0] in_b,
  input  logic             subtract,
  input  logic             shift,
`ifdef MP_ADDSUB_COND_SUB_EN
  input  logic             cond_sub,
`endif
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH:0]   out_result,
  output logic             out_carry
);

  // ceil((WIDTH+1)/CHUNK) add cycles.
  localparam int NCHUNK = (WIDTH + CHUNK) / CHUNK;
  localparam int EXT    = NCHUNK * CHUNK;
  localparam int CW     = (NCHUNK > 1) ? $clog2(NCHUNK) : 1;
  localparam logic [CW-1:0] LAST = CW'(NCHUNK - 1);

  typedef enum logic [1:0] {IDLE, CALC, HOLD} state_t;

  state_t          state;
  logic [EXT-1:0]  a_sr;      // A, shifted right one chunk per CALC cycle
  logic [EXT-1:0]  b_sr;      // B (inverted for subtract), shifted likewise
  logic [EXT-1:0]  acc;       // chunk sums enter from the MSB side
  logic            carry;
  logic [CW-1:0]   k;
  logic            sub_q;
  logic            shift_q;
`ifdef MP_ADDSUB_COND_SUB_EN
  logic            cond_q;
  logic [WIDTH-1:0] a_keep;   // untouched copy of A for the conditional result
`endif

  logic [CHUNK:0]  chunk_sum;
  logic [EXT-1:0]  acc_next;
  logic [WIDTH:0]  r_full;
  logic [WIDTH:0]  sel;
  logic [WIDTH:0]  res_next;
  logic            carry_out_next;

  // Current chunk sum and the full result as it will look after this cycle.
  assign chunk_sum = {1'b0, a_sr[CHUNK-1:0]} + {1'b0, b_sr[CHUNK-1:0]}
                   + (CHUNK+1)'(carry);
  assign acc_next  = (acc >> CHUNK) | (EXT'(chunk_sum[CHUNK-1:0]) << (EXT - CHUNK));
  // High extension bits above WIDTH are simply dropped here.
  assign r_full    = acc_next[WIDTH:0];

  // Result selection: difference/sum, or A on a failed conditional subtract.
  // NOTE: every always_comb output gets a default first so no latch is inferred.
  always_comb begin
    sel = r_full;
`ifdef MP_ADDSUB_COND_SUB_EN
    if (sub_q && cond_q && r_full[WIDTH]) sel = {1'b0, a_keep};
`endif
    res_next       = shift_q ? {1'b0, sel[WIDTH:1]} : sel;
    // For subtract, bit WIDTH of the two's-complement result is the borrow.
    carry_out_next = sub_q ? ~r_full[WIDTH] : r_full[WIDTH];
  end

  // Control FSM with registered handshake and result outputs.
  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values, independent of statement order.
  always_ff @(posedge clk) begin
    if (!resetn) begin
      state      <= IDLE;
      in_ready   <= 1'b1;
      out_valid  <= 1'b0;
      out_result <= '0;
      out_carry  <= 1'b0;
      carry      <= 1'b0;
      k          <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (in_valid) begin
            carry    <= subtract;
            k        <= '0;
            in_ready <= 1'b0;
            state    <= CALC;
          end
        end
        CALC: begin
          carry <= chunk_sum[CHUNK];
          k     <= k + CW'(1);
          if (k == LAST) begin
            out_result <= res_next;
            out_carry  <= carry_out_next;
            out_valid  <= 1'b1;
            state      <= HOLD;
          end
        end
        HOLD: begin
          if (out_ready) begin
            out_valid <= 1'b0;
            in_ready  <= 1'b1;
            state     <= IDLE;
          end
        end
        default: begin
          state     <= IDLE;
          in_ready  <= 1'b1;
          out_valid <= 1'b0;
        end
      endcase
    end
  end

  // Operand capture on accept and chunk shifting during CALC.
  // NOTE: the wide datapath registers carry no reset; they are always loaded
  // on accept before being read, and acc is fully overwritten by NCHUNK shifts.
  always_ff @(posedge clk) begin
    if (state == IDLE && in_valid) begin
      a_sr    <= EXT'(in_a);
      b_sr    <= subtract ? ~EXT'(in_b) : EXT'(in_b);
      sub_q   <= subtract;
      shift_q <= shift;
`ifdef MP_ADDSUB_COND_SUB_EN
      cond_q  <= cond_sub;
      a_keep  <= in_a;
`endif
    end else if (state == CALC) begin
      a_sr <= a_sr >> CHUNK;
      b_sr <= b_sr >> CHUNK;
      acc  <= acc_next;
    end
  end

endmodule
